// File: rtl/descriptor_memory.sv
// Descriptor table: NUM_DESCRIPTORS entries of {src, dst, payload pointer}
// plus a valid bit each. One registered read port (write-first), one write
// port sharing the same address, a synchronous clear and a running count of
// valid entries.
module descriptor_memory #(
    parameter int unsigned NUM_DESCRIPTORS = 16,
    parameter int unsigned ADDR_W          = $clog2(NUM_DESCRIPTORS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              write_enable_i,
    input  logic [63:0]       write_data_i,
    input  logic              clear_i,
    output logic [15:0]       src_address_o,
    output logic [15:0]       dst_address_o,
    output logic [31:0]       payload_ptr_o,
    output logic              valid_o,
    output logic [ADDR_W:0]   count_o
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [63:0]                mem_q [NUM_DESCRIPTORS];
    logic [63:0]                mem_d [NUM_DESCRIPTORS];
    logic [NUM_DESCRIPTORS-1:0] valid_q, valid_d;
    logic [63:0]                rd_data_q, rd_data_d;
    logic                       rd_valid_q, rd_valid_d;
    logic [ADDR_W:0]            count_q, count_d;

    logic                       addr_in_range;
    logic [ADDR_W-1:0]          idx;

    // Address decode: out-of-range indices never touch the array; they are
    // folded onto entry 0 so the index stays legal, and gated off below.
    always_comb begin
        addr_in_range = (32'(addr_i) < NUM_DESCRIPTORS);
        idx           = addr_in_range ? addr_i : '0;
    end

    // Next-state: clear wins over write; the read sees the post-write entry
    // (write-first), and the count grows only when an invalid entry fills.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        mem_d      = mem_q;
        valid_d    = valid_q;
        count_d    = count_q;
        rd_data_d  = '0;
        rd_valid_d = 1'b0;

        if (clear_i) begin
            mem_d   = '{default: '0};
            valid_d = '0;
            count_d = '0;
        end else begin
            if (write_enable_i && addr_in_range) begin
                mem_d[idx]   = write_data_i;
                valid_d[idx] = 1'b1;
                if (!valid_q[idx]) begin
                    count_d = count_q + CNT_ONE;
                end
            end
            if (addr_in_range) begin
                rd_data_d  = mem_d[idx];
                rd_valid_d = valid_d[idx];
            end
        end
    end

    // State registers: asynchronous reset empties the table immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the storage array is reset too, because a reset must
            // discard every stored descriptor, not just the valid bits.
            mem_q      <= '{default: '0};
            valid_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            mem_q      <= mem_d;
            valid_q    <= valid_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            count_q    <= count_d;
        end
    end

    // Output fields unpacked from the read register.
    always_comb begin
        src_address_o = rd_data_q[63:48];
        dst_address_o = rd_data_q[47:32];
        payload_ptr_o = rd_data_q[31:0];
        valid_o       = rd_valid_q;
        count_o       = count_q;
    end

endmodule

// File: tb/tb_descriptor_memory.sv
// Self-checking bench for descriptor_memory with a non-power-of-two depth,
// so that addresses beyond the table are representable on addr_i.
module tb_descriptor_memory;

    localparam int unsigned N  = 12;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned NA = 2 ** AW;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] addr_i;
    logic          write_enable_i;
    logic [63:0]   write_data_i;
    logic          clear_i;
    logic [15:0]   src_address_o;
    logic [15:0]   dst_address_o;
    logic [31:0]   payload_ptr_o;
    logic          valid_o;
    logic [AW:0]   count_o;

    descriptor_memory #(.NUM_DESCRIPTORS(N), .ADDR_W(AW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .addr_i         (addr_i),
        .write_enable_i (write_enable_i),
        .write_data_i   (write_data_i),
        .clear_i        (clear_i),
        .src_address_o  (src_address_o),
        .dst_address_o  (dst_address_o),
        .payload_ptr_o  (payload_ptr_o),
        .valid_o        (valid_o),
        .count_o        (count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain table of descriptors and valid flags.
    logic [63:0] m_mem   [NA];
    bit          m_valid [NA];
    logic [63:0] m_rd;
    bit          m_rd_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            m_mem[i]   = '0;
            m_valid[i] = 1'b0;
        end
        m_rd       = '0;
        m_rd_valid = 1'b0;
    endtask

    // One clock edge of the described behaviour: clear, else write then read.
    task automatic model_step(input int a, input bit we, input logic [63:0] d, input bit clr);
        if (clr) begin
            model_reset();
        end else begin
            if (we && a < N) begin
                m_mem[a]   = d;
                m_valid[a] = 1'b1;
            end
            if (a < N) begin
                m_rd       = m_mem[a];
                m_rd_valid = m_valid[a];
            end else begin
                m_rd       = '0;
                m_rd_valid = 1'b0;
            end
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] s, input logic [15:0] d,
                             input logic [31:0] p, input logic v, input int c);
        check({tag, ".src"},   64'(src_address_o), 64'(s));
        check({tag, ".dst"},   64'(dst_address_o), 64'(d));
        check({tag, ".pay"},   64'(payload_ptr_o), 64'(p));
        check({tag, ".valid"}, 64'(valid_o),       64'(v));
        check({tag, ".count"}, 64'(count_o),       64'(c));
    endtask

    task automatic check_model(input string tag);
        check_out(tag, m_rd[63:48], m_rd[47:32], m_rd[31:0], m_rd_valid, m_count());
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
    task automatic step(input int a, input bit we, input logic [63:0] d, input bit clr);
        addr_i         = AW'(a);
        write_enable_i = we;
        write_data_i   = d;
        clear_i        = clr;
        @(posedge clk_i);
        #1;
        model_step(a, we, d, clr);
    endtask

    typedef struct {
        int          addr;
        bit          we;
        logic [63:0] data;
        bit          clr;
        logic [15:0] src;
        logic [15:0] dst;
        logic [31:0] pay;
        logic        valid;
        int          count;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // Directed vectors with hand-derived expectations.
        vecs[0]  = '{0,  1, 64'h1234_5678_9ABC_DEF0, 0, 16'h1234, 16'h5678, 32'h9ABC_DEF0, 1, 1};
        vecs[1]  = '{0,  0, 64'h0,                   0, 16'h1234, 16'h5678, 32'h9ABC_DEF0, 1, 1};
        vecs[2]  = '{1,  1, 64'h1111_2222_3333_4444, 0, 16'h1111, 16'h2222, 32'h3333_4444, 1, 2};
        vecs[3]  = '{0,  0, 64'h0,                   0, 16'h1234, 16'h5678, 32'h9ABC_DEF0, 1, 2};
        vecs[4]  = '{5,  1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 16'hAAAA, 16'hBBBB, 32'hCCCC_DDDD, 1, 3};
        vecs[5]  = '{5,  1, 64'h5555_6666_7777_8888, 0, 16'h5555, 16'h6666, 32'h7777_8888, 1, 3};
        vecs[6]  = '{13, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0, 16'h0,    16'h0,    32'h0,         0, 3};
        vecs[7]  = '{13, 0, 64'h0,                   0, 16'h0,    16'h0,    32'h0,         0, 3};
        vecs[8]  = '{11, 1, 64'h0BAD_F00D_CAFE_BEEF, 0, 16'h0BAD, 16'hF00D, 32'hCAFE_BEEF, 1, 4};
        vecs[9]  = '{12, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 16'h0,    16'h0,    32'h0,         0, 4};
        vecs[10] = '{2,  1, 64'h2222_3333_4444_5555, 1, 16'h0,    16'h0,    32'h0,         0, 0};
        vecs[11] = '{2,  0, 64'h0,                   0, 16'h0,    16'h0,    32'h0,         0, 0};
        vecs[12] = '{0,  0, 64'h0,                   0, 16'h0,    16'h0,    32'h0,         0, 0};

        // Reset with a write and a clear presented: both must be discarded.
        rst_i          = 1'b1;
        addr_i         = AW'(3);
        write_enable_i = 1'b1;
        write_data_i   = 64'hFEED_FACE_0123_4567;
        clear_i        = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_out("reset_hold", 16'h0, 16'h0, 32'h0, 1'b0, 0);
        write_enable_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        step(3, 0, 64'h0, 0);
        check_out("post_reset_read", 16'h0, 16'h0, 32'h0, 1'b0, 0);

        // Table-driven directed vectors.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].addr, vecs[i].we, vecs[i].data, vecs[i].clr);
            check_out($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].pay,
                      vecs[i].valid, vecs[i].count);
        end

        // One-cycle read latency: changing addr_i alone does not move outputs.
        step(0, 1, 64'hA0A0_B0B0_C0C0_D0D0, 0);
        step(1, 1, 64'h1010_2020_3030_4040, 0);
        addr_i = AW'(0);
        #2;
        check_out("latency_hold", 16'h1010, 16'h2020, 32'h3030_4040, 1'b1, 2);
        step(0, 0, 64'h0, 0);
        check_out("latency_next", 16'hA0A0, 16'hB0B0, 32'hC0C0_D0D0, 1'b1, 2);

        // Mid-operation asynchronous reset: outputs clear before any edge.
        step(3, 1, 64'h3333_4444_5555_6666, 0);
        check_out("pre_async", 16'h3333, 16'h4444, 32'h5555_6666, 1'b1, 3);
        #2;
        rst_i = 1'b1;
        #1;
        check_out("async_reset", 16'h0, 16'h0, 32'h0, 1'b0, 0);
        model_reset();
        repeat (2) @(posedge clk_i);
        write_enable_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        step(0, 0, 64'h0, 0);
        check_out("after_reset_a0", 16'h0, 16'h0, 32'h0, 1'b0, 0);
        step(3, 0, 64'h0, 0);
        check_out("after_reset_a3", 16'h0, 16'h0, 32'h0, 1'b0, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            int          a;
            bit          we;
            bit          clr;
            logic [63:0] d;
            a   = $urandom_range(0, NA - 1);
            we  = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 39) == 0);
            d   = {$urandom, $urandom};
            step(a, we, d, clr);
            check_model($sformatf("rnd%0d", i));
            check($sformatf("rnd%0d.count_bound", i), 64'(count_o <= (AW + 1)'(N)), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/descriptor_memory.md
DESCRIPTOR_MEMORY -- requirements
Module: descriptor_memory

Interface
REQ-001 Parameter NUM_DESCRIPTORS, default 16, SHALL set the number of descriptor entries (legal range 2..256).
REQ-002 Parameter ADDR_W, default $clog2(NUM_DESCRIPTORS), SHALL set the address width.
REQ-003 Design SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_i  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 addr_i  input  ADDR_W  SHALL be the shared read/write entry index.
REQ-007 write_enable_i  input  1  SHALL request a write of write_data_i to entry addr_i when high.
REQ-008 write_data_i  input  64  SHALL carry the packed descriptor: [63:48] src, [47:32] dst, [31:0] payload pointer.
REQ-009 clear_i  input  1  SHALL request a synchronous invalidate-and-zero of all entries when high.
REQ-010 src_address_o  output  16  SHALL be the src field of the entry read.
REQ-011 dst_address_o  output  16  SHALL be the dst field of the entry read.
REQ-012 payload_ptr_o  output  32  SHALL be the payload pointer field of the entry read.
REQ-013 valid_o  output  1  SHALL be the valid flag of the entry read.
REQ-014 count_o  output  ADDR_W+1  SHALL be the number of currently valid entries.

Function
REQ-015 Storage SHALL be NUM_DESCRIPTORS entries of 64 data bits plus one valid bit each.
REQ-016 On a rising edge with write_enable_i=1, clear_i=0 and addr_i < NUM_DESCRIPTORS, the entry SHALL take write_data_i and its valid bit SHALL set.
REQ-017 Writes with addr_i >= NUM_DESCRIPTORS SHALL be ignored with no state change.
REQ-018 Read SHALL be registered: outputs on edge N+1 reflect entry addr_i sampled at edge N, i.e. one-cycle latency.
REQ-019 Read and write to the same address in the same cycle SHALL be write-first: outputs on the next edge show the new data with valid_o=1.
REQ-020 Reads with addr_i >= NUM_DESCRIPTORS SHALL return all-zero fields and valid_o=0.
REQ-021 The read register SHALL update every cycle, independent of write_enable_i.
REQ-022 clear_i=1 SHALL zero all entries and valid bits on the next edge, taking priority over a simultaneous write; the read register SHALL load zero that edge.
REQ-023 count_o SHALL be registered: increment on a write to a previously invalid entry, unchanged on an overwrite of a valid entry, and 0 after clear.
REQ-024 count_o SHALL never exceed NUM_DESCRIPTORS.

Reset
REQ-025 While rst_i=1, all entries, valid bits, the read register and count_o SHALL be zero immediately, without waiting for a clock edge.
REQ-026 All outputs SHALL read zero during reset and until the first post-reset write.
REQ-027 Writes and clears presented while rst_i=1 SHALL be discarded.
REQ-028 Reset asserted mid-operation SHALL discard all stored descriptors.

Verification
REQ-029 Write 64'h1234_5678_9ABC_DEF0 to addr 0, then read addr 0 -> src=16'h1234, dst=16'h5678, payload=32'h9ABC_DEF0, valid_o=1, count_o=1.
REQ-030 Write 64'h1111_2222_3333_4444 to addr 1, then read addr 1 -> src=16'h1111, dst=16'h2222, payload=32'h3333_4444, count_o=2; addr 0 is unchanged.
REQ-031 After REQ-030, pulse rst_i, then read addr 0 -> all fields 0, valid_o=0, count_o=0.
REQ-032 Write addr 5 with 64'hAAAA_BBBB_CCCC_DDDD while addr_i=5 -> the next edge shows src=16'hAAAA, dst=16'hBBBB, payload=32'hCCCC_DDDD; overwriting addr 5 leaves count_o unchanged.
REQ-033 With NUM_DESCRIPTORS=12, write addr 13 -> count_o unchanged and a read of addr 13 returns zeros with valid_o=0.
REQ-034 Assert clear_i together with a write to addr 2 -> all entries invalid, count_o=0, and addr 2 reads zero.
